// File: rtl/bcd7seg_scan_pkg.sv
// Shared constants for the 3-digit seven-segment scan driver: digit count,
// active-high gfedcba glyphs, and the digit-index type used by the scanner.
package bcd7seg_scan_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Element n is the glyph for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_t;

    function automatic logic [3:0] select_nibble(input logic [11:0] value,
                                                 input digit_t      dig);
        logic [3:0] nib;
        case (dig)
            DIG_TENS:     nib = value[7:4];
            DIG_HUNDREDS: nib = value[11:8];
            default:      nib = value[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/bcd7seg_scan_decode.sv
// Combinational BCD nibble to active-high gfedcba pattern; non-decimal
// nibbles render as a dash, and blank forces all segments off.
module bcd7seg_decode
    import bcd7seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        if (blank) begin
            pattern = SEG_BLANK;
        end else if (nibble <= 4'd9) begin
            pattern = SEG_DIGITS[nibble];
        end
    end

endmodule

// File: rtl/bcd7seg_scan.sv
// Time-multiplexed 3-digit seven-segment driver with a one-deep BCD buffer
// committed at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd7seg_scan
    import bcd7seg_scan_pkg::*;
#(
    parameter int DIV            = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done
);

    localparam int             CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    function automatic logic [6:0] seg_drive(input logic [6:0] pat);
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

    function automatic logic [2:0] an_drive(input logic [2:0] onehot);
        return AN_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    logic [CNT_W-1:0] cnt_p0, cnt_nxt;
    digit_t           idx_p0, idx_nxt;
    logic [11:0]      disp_p0;
    logic [11:0]      pend_p0;
    logic             pend_full_p0, pend_full_nxt;
    logic             wrap, boundary, xfer;
    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       pattern;
    logic [6:0]       seg_p1;
    logic [2:0]       an_p1;

    // ---- stage p0: dwell counter, digit index, buffer control ----
    always_comb begin
        wrap          = (cnt_p0 == CNT_LAST);
        boundary      = wrap && (idx_p0 == DIG_HUNDREDS);
        xfer          = bcd_valid && !pend_full_p0;
        cnt_nxt       = wrap ? '0 : cnt_p0 + CNT_W'(1);
        idx_nxt       = idx_p0;
        pend_full_nxt = pend_full_p0;
        if (wrap) begin
            case (idx_p0)
                DIG_ONES: idx_nxt = DIG_TENS;
                DIG_TENS: idx_nxt = DIG_HUNDREDS;
                default:  idx_nxt = DIG_ONES;
            endcase
        end
        // A full buffer never accepts, so drain and fill cannot coincide.
        if (boundary && pend_full_p0) begin
            pend_full_nxt = 1'b0;
        end else if (xfer) begin
            pend_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0       <= '0;
            idx_p0       <= DIG_ONES;
            disp_p0      <= '0;
            pend_full_p0 <= 1'b0;
        end else begin
            cnt_p0       <= cnt_nxt;
            idx_p0       <= idx_nxt;
            pend_full_p0 <= pend_full_nxt;
            if (boundary && pend_full_p0) begin
                disp_p0 <= pend_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            pend_p0 <= bcd_in;
        end
    end

    assign bcd_ready  = !pend_full_p0;
    assign frame_done = boundary;

    always_comb begin
        nibble = select_nibble(disp_p0, idx_p0);
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((idx_p0 == DIG_HUNDREDS) && (disp_p0[11:8] == 4'd0)) ||
                ((idx_p0 == DIG_TENS)     && (disp_p0[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
    end

    bcd7seg_decode u_decode (
        .nibble  (nibble),
        .blank   (blank),
        .pattern (pattern)
    );

    // ---- stage p1: segment and anode registers switch on the same edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1 <= seg_drive(SEG_BLANK);
            an_p1  <= an_drive(3'b000);
        end else begin
            seg_p1 <= seg_drive(pattern);
            an_p1  <= an_drive(3'b001 << idx_p0);
        end
    end

    assign seg = seg_p1;
    assign an  = an_p1;

endmodule

// File: tb/tb_bcd7seg_scan.sv
// Directed bench for bcd7seg_scan with DIV=4 and active-low outputs.
module tb_bcd7seg_scan;

    localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h00;
`else
    localparam logic [6:0] ZB = 7'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_done;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [2:0] an_hot;
        logic [6:0] pat;
        logic       fd;
    } idle_vec_t;

    typedef struct {
        logic [11:0] bcd;
        logic [6:0]  ones;
        logic [6:0]  tens;
        logic [6:0]  hund;
    } xfer_vec_t;

    idle_vec_t idle_tab [13];
    xfer_vec_t xfer_tab [5];

    bcd7seg_scan #(
        .DIV            (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input logic [2:0] an_hot, input logic [6:0] pat);
        chk({nm, "_an"}, {29'd0, an}, {29'd0, ~an_hot});
        chk({nm, "_seg"}, {25'd0, seg}, {25'd0, ~pat});
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < 3 * DIV + 2) begin
            tick();
            n++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // Starts at the first sample where the ones digit is on the pins.
    task automatic show(input string nm, input logic [6:0] o, input logic [6:0] t,
                        input logic [6:0] h);
        chk_out({nm, "_ones"}, 3'b001, o);
        repeat (DIV) tick();
        chk_out({nm, "_tens"}, 3'b010, t);
        repeat (DIV) tick();
        chk_out({nm, "_hund"}, 3'b100, h);
    endtask

    initial begin
        int n;

        for (int k = 0; k < 13; k++) begin
            idle_tab[k].pat = (k >= 4 && k < 12) ? ZB : 7'h3F;
            idle_tab[k].fd  = 1'b0;
        end
        idle_tab[0].an_hot  = 3'b001; idle_tab[1].an_hot  = 3'b001;
        idle_tab[2].an_hot  = 3'b001; idle_tab[3].an_hot  = 3'b001;
        idle_tab[4].an_hot  = 3'b010; idle_tab[5].an_hot  = 3'b010;
        idle_tab[6].an_hot  = 3'b010; idle_tab[7].an_hot  = 3'b010;
        idle_tab[8].an_hot  = 3'b100; idle_tab[9].an_hot  = 3'b100;
        idle_tab[10].an_hot = 3'b100; idle_tab[11].an_hot = 3'b100;
        idle_tab[12].an_hot = 3'b001;
        idle_tab[10].fd     = 1'b1;

        xfer_tab[0] = '{12'h123, 7'h4F, 7'h5B, 7'h06};
        xfer_tab[1] = '{12'h1A3, 7'h4F, 7'h40, 7'h06};
        xfer_tab[2] = '{12'h007, 7'h07, ZB,    ZB};
        xfer_tab[3] = '{12'h0F0, 7'h3F, 7'h40, ZB};
        xfer_tab[4] = '{12'h989, 7'h6F, 7'h7F, 7'h6F};

        rst = 1'b1; bcd_in = 12'h000; bcd_valid = 1'b0;
        repeat (3) tick();
        chk_out("reset", 3'b000, 7'h00);
        chk("reset_ready", {31'd0, bcd_ready}, 32'd1);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);

        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tick();
            chk_out($sformatf("idle%0d", k + 1), idle_tab[k].an_hot, idle_tab[k].pat);
            chk($sformatf("idle%0d_fd", k + 1), {31'd0, frame_done}, {31'd0, idle_tab[k].fd});
            chk($sformatf("idle%0d_rdy", k + 1), {31'd0, bcd_ready}, 32'd1);
        end

        for (int i = 0; i < 5; i++) begin
            bcd_in = xfer_tab[i].bcd; bcd_valid = 1'b1;
            tick();
            bcd_valid = 1'b0;
            chk($sformatf("x%0d_busy", i), {31'd0, bcd_ready}, 32'd0);
            wait_fd(n);
            chk($sformatf("x%0d_busy_at_fd", i), {31'd0, bcd_ready}, 32'd0);
            tick();
            chk($sformatf("x%0d_ready_back", i), {31'd0, bcd_ready}, 32'd1);
            tick();
            show($sformatf("x%0d", i), xfer_tab[i].ones, xfer_tab[i].tens, xfer_tab[i].hund);
        end

        // Transfer on the boundary cycle must wait one full frame.
        wait_fd(n);
        chk("coin_ready", {31'd0, bcd_ready}, 32'd1);
        bcd_in = 12'h250; bcd_valid = 1'b1;
        tick();
        bcd_valid = 1'b0;
        chk("coin_busy", {31'd0, bcd_ready}, 32'd0);
        tick();
        show("coin_old", 7'h6F, 7'h7F, 7'h6F);
        wait_fd(n);
        chk("coin_busy_at_fd", {31'd0, bcd_ready}, 32'd0);
        tick();
        chk("coin_ready_back", {31'd0, bcd_ready}, 32'd1);
        tick();
        show("coin_new", 7'h3F, 7'h6D, 7'h5B);

        // Back-to-back: second offer held while busy is only taken after drain.
        bcd_in = 12'h045; bcd_valid = 1'b1;
        tick();
        bcd_in = 12'h678;
        chk("b2b_busy", {31'd0, bcd_ready}, 32'd0);
        wait_fd(n);
        chk("b2b_busy_at_fd", {31'd0, bcd_ready}, 32'd0);
        tick();
        chk("b2b_ready_back", {31'd0, bcd_ready}, 32'd1);
        tick();
        bcd_valid = 1'b0;
        chk("b2b_second_taken", {31'd0, bcd_ready}, 32'd0);
        show("b2b_045", 7'h6D, 7'h66, ZB);
        wait_fd(n);
        tick();
        tick();
        show("b2b_678", 7'h7F, 7'h07, 7'h7D);

        // Reset mid-frame with a pending value: pending data is discarded.
        bcd_in = 12'h999; bcd_valid = 1'b1;
        tick();
        bcd_valid = 1'b0;
        chk("mid_busy", {31'd0, bcd_ready}, 32'd0);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 3'b000, 7'h00);
        chk("mid_rst_ready", {31'd0, bcd_ready}, 32'd1);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        tick();
        chk_out("mid_first", 3'b001, 7'h3F);
        wait_fd(n);
        chk("mid_fd_latency", n, 32'd10);
        tick();
        tick();
        show("mid_after", 7'h3F, ZB, ZB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd7seg_scan.md
# bcd7seg_scan

Time-multiplexed 3-digit seven-segment display driver placed directly downstream of the binary-to-BCD converter. It accepts a 12-bit packed BCD value (hundreds/tens/ones) through a valid/ready handshake and buffers it. At the next frame boundary it commits the value to the display. It then scans the three common-anode/cathode digits continuously at a programmable dwell rate.

## Interface
- DIV, 50000: clock cycles each digit is driven (dwell); legal range ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs active-low.
- AN_ACTIVE_LOW, 1: 1 = digit-enable outputs active-low.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bcd_in  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- bcd_valid  in  1  bcd_in is valid this cycle.
- bcd_ready  out  1  pending buffer empty; a transfer occurs when bcd_valid & bcd_ready.
- seg  out  7  segments, bit0=a … bit6=g.
- an  out  3  digit enables: an[0] ones, an[1] tens, an[2] hundreds.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- State: dwell counter cnt (0..DIV-1), digit index idx (0,1,2), display register disp[11:0], pending register pend[11:0] plus flag pend_full.
- Scan: cnt increments each cycle. At cnt==DIV-1, cnt wraps to 0 and idx advances 0→1→2→0.
- Frame boundary is the idx 2→0 wrap. On that cycle: if pend_full, then disp←pend and pend_full←0. frame_done=1 for that cycle only, regardless of pend_full.
- Handshake: bcd_ready = ~pend_full, combinational from the flag. On valid&ready, pend←bcd_in and pend_full←1. bcd_valid while not ready is ignored; there is no queueing.
- A transfer on the same cycle as a frame boundary lands in pend. It is displayed at the following boundary, never the current one.
- Decode of the selected nibble, active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles A–F give 40 (dash). Blank gives 00. Output is inverted when SEG_ACTIVE_LOW.
- Exactly one an bit is active at a time: the bit matching idx. Polarity follows AN_ACTIVE_LOW.

## Timing
- Reset values:
  - cnt=0, idx=0, disp=000, pend_full=0.
  - bcd_ready=1, frame_done=0.
  - seg all off, an all off (inactive levels per polarity parameters).
- seg and an are registered, with 1 cycle latency from (idx, disp). They change on the same edge, so there is no cross-digit glitch.
- First cycle after rst deasserts: outputs show digit 0 of disp=000.
- Each digit is visible for exactly DIV cycles. A frame is 3·DIV cycles.
- Commit latency from an accepted transfer to display: 1 to 3·DIV+1 cycles, depending on position in the frame.
- bcd_ready rises the cycle after the boundary that drains pend.
- rst asserted mid-frame or with pend_full=1: pend is discarded and all state returns to reset values on that edge.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blanked (seg 00) when disp[11:8]==0.
  - Tens digit is blanked when disp[11:8]==0 and disp[7:4]==0.
  - Ones digit is never blanked.
  - an is still scanned normally.
- Undefined: all three digits are always decoded, so "007" displays as 007.

## Structure
- Shared constants package: NUM_DIGITS=3, the ten digit segment patterns, SEG_DASH=7'h40, SEG_BLANK=7'h00.
- One combinational sub-module, bcd7seg_decode: 4-bit nibble plus blank flag in, 7-bit active-high pattern out. Polarity inversion is done in the parent.
- Parent holds the counters, handshake, pending/display registers and output registers.

## Test plan
- Reset then idle, DIV=4: outputs off during rst. Then an cycles ones→tens→hundreds every 4 cycles, seg=3F each digit, frame_done every 12 cycles.
- Transfer 0x123 mid-frame: bcd_ready low until the next boundary. After it, ones=4F, tens=5B, hundreds=06.
- Back-to-back: 0x045 accepted, then 0x678 offered while not ready. 0x678 is ignored. After the boundary 045 is displayed, and 0x678 is accepted once ready returns.
- Transfer coincident with the boundary: value is displayed one full frame later, not at the current boundary.
- Invalid nibble 0x1A3: tens shows 40.
- With LEADING_ZERO_BLANK_EN, value 0x007: hundreds and tens seg off, ones=07. Without the macro, both show 3F.
